// File: rtl/fwd_pkg.sv
// Shared constants for the forwarding/hazard unit: default register address
// width, the register-file select encoding and the select-width helper.
package fwd_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int FWD_RF     = 0;

  function automatic int sel_w(input int stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/fwd_src_match.sv
// Priority match of one ID source operand against the stage tracker.
// Reports the youngest producing stage and whether this operand must stall.
module fwd_src_match
  import fwd_pkg::*;
#(
  parameter int REG_ADDR_W = fwd_pkg::REG_ADDR_W,
  parameter int STAGES     = 3,
  parameter int LOAD_STAGE = 2,
  parameter int SEL_W      = fwd_pkg::sel_w(3)
) (
  input  logic                         i_enable_forward,
  input  logic [REG_ADDR_W-1:0]        i_src,
  input  logic                         i_src_valid,
  input  logic [STAGES-1:0]            i_valid,
  input  logic [STAGES-1:0]            i_wb_en,
  input  logic [STAGES-1:0]            i_is_load,
  input  logic [STAGES*REG_ADDR_W-1:0] i_dest,
  output logic [SEL_W-1:0]             o_sel,
  output logic                         o_hazard
);

  logic [SEL_W-1:0] w_young;
  logic             w_found;
  logic             w_young_load;
  logic             w_early_hit;

  // Scan oldest to youngest so the smallest matching stage overwrites last.
  always_comb begin
    w_young      = '0;
    w_found      = 1'b0;
    w_young_load = 1'b0;
    w_early_hit  = 1'b0;
    for (int k = STAGES; k >= 1; k--) begin
      if (i_valid[k-1] && i_wb_en[k-1] && i_src_valid &&
          (i_dest[(k-1)*REG_ADDR_W +: REG_ADDR_W] == i_src)) begin
        w_young      = SEL_W'(k);
        w_found      = 1'b1;
        w_young_load = i_is_load[k-1];
        if (k < STAGES) w_early_hit = 1'b1;
      end
    end
  end

  always_comb begin
    o_sel    = SEL_W'(FWD_RF);
    o_hazard = 1'b0;
    if (i_enable_forward) begin
      o_sel    = w_young;
      o_hazard = w_found && w_young_load && (int'(w_young) < LOAD_STAGE);
    end else begin
      // Interlock mode: the final stage writes the register file before ID reads it.
      o_hazard = w_early_hit;
    end
  end

endmodule

// File: rtl/forward_hazard_unit.sv
// Tracks destination registers of the stages after ID and produces per-source
// forwarding selects, the load-use / interlock stall and a stall-cycle counter.
module forward_hazard_unit
  import fwd_pkg::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int REG_ADDR_W = fwd_pkg::REG_ADDR_W,
  parameter int STAGES     = 3,
  parameter int LOAD_STAGE = 2,
  parameter int CNT_W      = 16,
  localparam int SEL_W     = fwd_pkg::sel_w(STAGES)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable_forward,
  input  logic                          id_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src,
  input  logic [NUM_SRC-1:0]            id_src_valid,
  input  logic [REG_ADDR_W-1:0]         id_dest,
  input  logic                          id_wb_en,
  input  logic                          id_mem_read,
  input  logic                          flush,
  input  logic                          stall_ext,
  output logic [NUM_SRC*SEL_W-1:0]      fwd_sel,
  output logic                          hazard_stall,
  output logic [CNT_W-1:0]              stall_count
);

  logic [STAGES-1:0]                  r_valid;
  logic [STAGES-1:0]                  r_wb_en;
  logic [STAGES-1:0]                  r_is_load;
  logic [STAGES-1:0][REG_ADDR_W-1:0]  r_dest;
  logic [CNT_W-1:0]                   r_stall_count;
  logic [NUM_SRC-1:0]                 w_haz;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      fwd_src_match #(
        .REG_ADDR_W (REG_ADDR_W),
        .STAGES     (STAGES),
        .LOAD_STAGE (LOAD_STAGE),
        .SEL_W      (SEL_W)
      ) u_match (
        .i_enable_forward (enable_forward),
        .i_src            (id_src[gi*REG_ADDR_W +: REG_ADDR_W]),
        .i_src_valid      (id_src_valid[gi]),
        .i_valid          (r_valid),
        .i_wb_en          (r_wb_en),
        .i_is_load        (r_is_load),
        .i_dest           (r_dest),
        .o_sel            (fwd_sel[gi*SEL_W +: SEL_W]),
        .o_hazard         (w_haz[gi])
      );
    end
  endgenerate

  assign hazard_stall = (|w_haz) && id_valid && !flush;
  assign stall_count  = r_stall_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid       <= '0;
      r_wb_en       <= '0;
      r_is_load     <= '0;
      r_dest        <= '0;
      r_stall_count <= '0;
    end else if (!stall_ext) begin
      for (int k = STAGES - 1; k >= 1; k--) begin
        r_valid[k]   <= r_valid[k-1];
        r_wb_en[k]   <= r_wb_en[k-1];
        r_is_load[k] <= r_is_load[k-1];
        r_dest[k]    <= r_dest[k-1];
      end
      // A stalled or flushed ID instruction enters EXE as a bubble.
      r_valid[0]   <= id_valid && !flush && !hazard_stall;
      r_wb_en[0]   <= id_wb_en;
      r_is_load[0] <= id_mem_read;
      r_dest[0]    <= id_dest;
      if (hazard_stall && (r_stall_count != {CNT_W{1'b1}}))
        r_stall_count <= r_stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Directed-vector bench for forward_hazard_unit with an expectation queue
// drained by a negedge monitor; a CNT_W=4 instance covers counter saturation.
module tb_forward_hazard_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable_forward;
  logic        id_valid;
  logic [9:0]  id_src;
  logic [1:0]  id_src_valid;
  logic [4:0]  id_dest;
  logic        id_wb_en;
  logic        id_mem_read;
  logic        flush;
  logic        stall_ext;
  logic [3:0]  fwd_sel, fwd_sel4;
  logic        hazard_stall, hazard_stall4;
  logic [15:0] stall_count;
  logic [3:0]  stall_count4;

  always #5 clk = ~clk;

  forward_hazard_unit dut (
    .clk(clk), .rst(rst), .enable_forward(enable_forward), .id_valid(id_valid),
    .id_src(id_src), .id_src_valid(id_src_valid), .id_dest(id_dest),
    .id_wb_en(id_wb_en), .id_mem_read(id_mem_read), .flush(flush),
    .stall_ext(stall_ext), .fwd_sel(fwd_sel), .hazard_stall(hazard_stall),
    .stall_count(stall_count)
  );

  forward_hazard_unit #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .enable_forward(enable_forward), .id_valid(id_valid),
    .id_src(id_src), .id_src_valid(id_src_valid), .id_dest(id_dest),
    .id_wb_en(id_wb_en), .id_mem_read(id_mem_read), .flush(flush),
    .stall_ext(stall_ext), .fwd_sel(fwd_sel4), .hazard_stall(hazard_stall4),
    .stall_count(stall_count4)
  );

  typedef struct {
    string       nm;
    logic [1:0]  sel0;
    logic [1:0]  sel1;
    logic        stall;
    logic [15:0] cnt16;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_cnt16  = 0;
  int   m_cnt4   = 0;

  task automatic chk(input string nm, input string what, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s %s: got %0h expected %0h", nm, what, act, req);
    end
  endtask

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.nm, "fwd_sel0", {14'd0, fwd_sel[1:0]}, {14'd0, e.sel0});
      chk(e.nm, "fwd_sel1", {14'd0, fwd_sel[3:2]}, {14'd0, e.sel1});
      chk(e.nm, "hazard_stall", {15'd0, hazard_stall}, {15'd0, e.stall});
      chk(e.nm, "stall_count", stall_count, e.cnt16);
      chk(e.nm, "stall_count4", {12'd0, stall_count4}, {12'd0, e.cnt4});
    end
  end

  // One clock of stimulus plus its hand-computed selects/stall; the counters
  // come from a small saturating model of the stall history.
  task automatic cyc(input string nm, input logic rs, input logic ef, input logic fl,
                     input logic se, input logic idv,
                     input logic [4:0] s0, input logic v0, input logic [4:0] s1, input logic v1,
                     input logic [4:0] d, input logic wb, input logic ld,
                     input logic [1:0] e0, input logic [1:0] e1, input logic est);
    exp_t e;
    @(posedge clk);
    #1;
    rst = rs; enable_forward = ef; flush = fl; stall_ext = se; id_valid = idv;
    id_src = {s1, s0}; id_src_valid = {v1, v0};
    id_dest = d; id_wb_en = wb; id_mem_read = ld;
    e.nm = nm; e.sel0 = e0; e.sel1 = e1; e.stall = est;
    e.cnt16 = 16'(m_cnt16); e.cnt4 = 4'(m_cnt4);
    q.push_back(e);
    if (rs) begin
      m_cnt16 = 0; m_cnt4 = 0;
    end else if (!se && est) begin
      if (m_cnt16 < 65535) m_cnt16++;
      if (m_cnt4 < 15) m_cnt4++;
    end
  endtask

  task automatic idle(input string nm, input logic ef);
    cyc(nm, 0, ef, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 2'd0, 2'd0, 0);
  endtask

  initial begin
    rst = 1'b1; enable_forward = 1'b1; id_valid = 1'b0; id_src = '0; id_src_valid = '0;
    id_dest = '0; id_wb_en = 1'b0; id_mem_read = 1'b0; flush = 1'b0; stall_ext = 1'b0;
    repeat (2) @(posedge clk);

    idle("reset_idle", 1);
    // ADD r3 then consumer: forwarded from stage 1, 2, 3 as it ages
    cyc("add_r3",   0,1,0,0,1, 5'd0,0, 5'd0,0, 5'd3,1,0, 2'd0,2'd0,0);
    cyc("fwd_s1",   0,1,0,0,1, 5'd3,1, 5'd0,0, 5'd0,0,0, 2'd1,2'd0,0);
    cyc("fwd_s2",   0,1,0,0,1, 5'd3,1, 5'd3,1, 5'd0,0,0, 2'd2,2'd2,0);
    cyc("fwd_s3",   0,1,0,0,1, 5'd3,1, 5'd0,0, 5'd0,0,0, 2'd3,2'd0,0);
    repeat (3) idle("drain_a", 1);
    cyc("drained",  0,1,0,0,0, 5'd3,1, 5'd0,0, 5'd0,0,0, 2'd0,2'd0,0);
    // r4 written twice: youngest producer wins
    cyc("add_r4a",  0,1,0,0,1, 5'd0,0, 5'd0,0, 5'd4,1,0, 2'd0,2'd0,0);
    cyc("add_r4b",  0,1,0,0,1, 5'd0,0, 5'd0,0, 5'd4,1,0, 2'd0,2'd0,0);
    cyc("young_s1", 0,1,0,0,1, 5'd4,0, 5'd4,1, 5'd0,0,0, 2'd0,2'd1,0);
    cyc("young_s2", 0,1,0,0,1, 5'd0,0, 5'd4,1, 5'd0,0,0, 2'd0,2'd2,0);
    repeat (3) idle("drain_b", 1);
    // load-use: one stall, then forward from stage 2
    cyc("ldr_r5",   0,1,0,0,1, 5'd0,0, 5'd0,0, 5'd5,1,1, 2'd0,2'd0,0);
    cyc("ld_stall", 0,1,0,0,1, 5'd5,1, 5'd0,0, 5'd6,1,0, 2'd1,2'd0,1);
    cyc("ld_fwd",   0,1,0,0,1, 5'd5,1, 5'd0,0, 5'd6,1,0, 2'd2,2'd0,0);
    repeat (3) idle("drain_c", 1);
    // interlock mode: two stall cycles, no forwarding
    cyc("nf_add_r2",0,0,0,0,1, 5'd0,0, 5'd0,0, 5'd2,1,0, 2'd0,2'd0,0);
    cyc("nf_st1",   0,0,0,0,1, 5'd2,1, 5'd0,0, 5'd7,1,0, 2'd0,2'd0,1);
    cyc("nf_st2",   0,0,0,0,1, 5'd2,1, 5'd0,0, 5'd7,1,0, 2'd0,2'd0,1);
    cyc("nf_go",    0,0,0,0,1, 5'd2,1, 5'd0,0, 5'd7,1,0, 2'd0,2'd0,0);
    repeat (3) idle("drain_d", 1);
    // load hazard frozen by stall_ext, then flushed
    cyc("ldr_r5b",  0,1,0,0,1, 5'd0,0, 5'd0,0, 5'd5,1,1, 2'd0,2'd0,0);
    repeat (3) cyc("ext_hold", 0,1,0,1,1, 5'd5,1, 5'd0,0, 5'd6,1,0, 2'd1,2'd0,1);
    cyc("flush",    0,1,0+1,0,1, 5'd5,1, 5'd0,0, 5'd6,1,0, 2'd1,2'd0,0);
    cyc("post_fl",  0,1,0,0,1, 5'd5,1, 5'd6,1, 5'd0,0,0, 2'd2,2'd0,0);
    repeat (3) idle("drain_e", 1);
    // 20 interlock stalls: 16-bit counter climbs, 4-bit counter saturates
    cyc("sat_w_r2", 0,0,0,0,1, 5'd0,0, 5'd0,0, 5'd2,1,0, 2'd0,2'd0,0);
    for (int r = 0; r < 10; r++) begin
      cyc("sat_st1", 0,0,0,0,1, 5'd2,1, 5'd0,0, 5'd2,1,0, 2'd0,2'd0,1);
      cyc("sat_st2", 0,0,0,0,1, 5'd2,1, 5'd0,0, 5'd2,1,0, 2'd0,2'd0,1);
      cyc("sat_go",  0,0,0,0,1, 5'd2,1, 5'd0,0, 5'd2,1,0, 2'd0,2'd0,0);
    end
    // reset in the middle of a stall
    cyc("rst_mid",  1,0,0,0,1, 5'd2,1, 5'd0,0, 5'd0,0,0, 2'd0,2'd0,1);
    cyc("post_rst", 0,0,0,0,1, 5'd2,1, 5'd0,0, 5'd0,0,0, 2'd0,2'd0,0);
    idle("final", 1);

    for (int w = 0; w < 10 && q.size() > 0; w++) @(negedge clk);
    if (q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/forward_hazard_unit.md
FORWARD_HAZARD_UNIT -- requirements
Module: forward_hazard_unit

Interface
REQ-001 Parameter NUM_SRC, default 2: number of ID-stage source operands checked.
REQ-002 Parameter REG_ADDR_W, default 5: register address width.
REQ-003 Parameter STAGES, default 3: tracked stages after ID (1=EXE, 2=MEM, 3=WB).
REQ-004 Parameter LOAD_STAGE, default 2: first stage whose load result is forwardable.
REQ-005 Parameter CNT_W, default 16: stall counter width; SEL_W = clog2(STAGES+1).
REQ-006 One clock; reset is synchronous and active-high; ports are clk and rst.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 enable_forward  in  1  1 = forwarding allowed; 0 = stall-only interlock.
REQ-010 id_valid  in  1  ID holds a real instruction.
REQ-011 id_src  in  NUM_SRC*REG_ADDR_W  source register numbers; slot i at bits [i*REG_ADDR_W +: REG_ADDR_W].
REQ-012 id_src_valid  in  NUM_SRC  per-source "operand is read".
REQ-013 id_dest  in  REG_ADDR_W  ID destination register.
REQ-014 id_wb_en  in  1  ID instruction writes id_dest.
REQ-015 id_mem_read  in  1  ID instruction is a load.
REQ-016 flush  in  1  squash the ID instruction (taken branch).
REQ-017 stall_ext  in  1  global pipeline freeze (memory wait).
REQ-018 fwd_sel  out  NUM_SRC*SEL_W  per source: 0 = register file, k = value of stage k.
REQ-019 hazard_stall  out  1  hold IF/ID and insert a bubble into EXE.
REQ-020 stall_count  out  CNT_W  saturating count of hazard-stall cycles.

Function
REQ-021 Tracker holds, per stage k = 1..STAGES: valid, dest, wb_en, is_load.
REQ-022 stall_ext=1: the tracker and stall_count shall hold.
REQ-023 Otherwise each clock: stage k+1 <= stage k; stage 1 <= ID fields, valid = id_valid & ~flush & ~hazard_stall.
REQ-024 Stage k matches source i when valid & wb_en & dest == src_i & id_src_valid[i].
REQ-025 enable_forward=1: fwd_sel[i] = smallest matching k, else 0; the youngest stage wins.
REQ-026 enable_forward=1: raw hazard on source i when its youngest match has is_load=1 and k < LOAD_STAGE.
REQ-027 enable_forward=0: fwd_sel = 0, and raw hazard on any match in stages 1..STAGES-1; the register file writes the stage-STAGES value before the read.
REQ-028 hazard_stall = OR of raw hazards & id_valid & ~flush; it is combinational with zero latency.
REQ-029 stall_count shall increment when hazard_stall=1 and stall_ext=0, and saturate at 2^CNT_W-1.
REQ-030 flush with a hazard present: hazard_stall=0, stage 1 gets a bubble.

Reset
REQ-031 rst=1 at the clock edge: all tracker valid bits = 0 and stall_count = 0; rst has priority over stall_ext.
REQ-032 After reset with idle inputs: fwd_sel = 0 and hazard_stall = 0.
REQ-033 Reset mid-stall drops all in-flight entries; no stall persists.

Structure
REQ-034 Shared package fwd_pkg holds REG_ADDR_W, the FWD_RF=0 encoding, and the SEL_W clog2 helper.
REQ-035 Sub-module fwd_src_match (priority match for one source against the tracker) shall be instantiated NUM_SRC times.

Verification (NUM_SRC=2, STAGES=3, LOAD_STAGE=2)
REQ-036 ADD r3 in stage 1, ID src0=r3 -> fwd_sel[0]=1, hazard_stall=0.
REQ-037 r4 written in stages 1 and 2, ID src1=r4 -> fwd_sel[1]=1.
REQ-038 LDR r5 in stage 1, ID src0=r5 -> hazard_stall=1 for exactly one cycle, then fwd_sel[0]=2, stall_count=1.
REQ-039 enable_forward=0, ADD r2 in stage 1, ID reads r2 -> two stall cycles, fwd_sel=0, proceeds once r2 reaches stage 3.
REQ-040 Load hazard with stall_ext=1 for 3 cycles -> tracker frozen, stall_count unchanged; flush asserted -> hazard_stall=0, bubble in stage 1.
REQ-041 CNT_W=4, 20 stall cycles -> stall_count=15; rst mid-stall -> stall_count=0, hazard_stall=0 on the next cycle.
